// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    // Width of one byte lane; halfword lanes are two of these.
    localparam int LANE_W = 8;
    localparam int HALF_W = 2 * LANE_W;

    // Access size encodings; 2'b11 is reserved and always faults.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MERGE,
        ST_WRITE
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: extracts and extends a load lane from a memory
// word, and merges store data into the addressed lane of a memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [LANE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    // Halfword accesses are aligned, so only i_off[1] selects the half.
    assign w_byte = i_rdata[int'(i_off) * LANE_W +: LANE_W];
    assign w_half = i_rdata[int'(i_off[1]) * HALF_W +: HALF_W];

    // Load path: pick the lane and sign- or zero-extend it; words pass through.
    always_comb begin
        o_load = i_rdata;
        case (i_size)
            SIZE_B:  o_load = {{(32 - LANE_W){i_signed & w_byte[LANE_W-1]}}, w_byte};
            SIZE_H:  o_load = {{(32 - HALF_W){i_signed & w_half[HALF_W-1]}}, w_half};
            default: o_load = i_rdata;
        endcase
    end

    // Store path: overwrite only the addressed lane of the current memory word.
    always_comb begin
        o_merge = i_rdata;
        case (i_size)
            SIZE_B:  o_merge[int'(i_off) * LANE_W +: LANE_W]    = i_wdata[LANE_W-1:0];
            SIZE_H:  o_merge[int'(i_off[1]) * HALF_W +: HALF_W] = i_wdata[HALF_W-1:0];
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: byte/halfword/word loads and stores against a
// word-wide memory, with read-modify-write for sub-word stores and fault
// detection for misaligned, reserved-size and out-of-range accesses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready; accepts a request, faults respond from here
// ST_LOAD  | memory word on Mem_R_Data, lane extracted into Resp_RData
// ST_MERGE | memory word read, store lane merged into r_data
// ST_WRITE | Mem_W_En high, r_data written to memory this cycle
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS   = 64,
    parameter bit CHECK_RANGE = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic        Req_Write,
    input  logic [1:0]  Req_Size,
    input  logic        Req_Signed,
    input  logic [31:0] Req_Addr,
    input  logic [31:0] Req_WData,
    output logic        Resp_Valid,
    output logic [31:0] Resp_RData,
    output logic        Resp_Fault,
    output logic [31:0] Mem_Addr,
    output logic        Mem_W_En,
    output logic [31:0] Mem_W_Data,
    input  logic [31:0] Mem_R_Data
);

    // 33 bits so a memory filling the whole 32-bit space still compares correctly.
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    lsu_state_t  r_state, w_next;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_size;
    logic        r_signed;
    logic        r_resp_valid;
    logic        r_resp_fault;
    logic [31:0] r_resp_rdata;
    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_load;
    logic [31:0] w_merge;

    assign Req_Ready  = (r_state == ST_IDLE);
    assign w_accept   = Req_Valid & Req_Ready;
    assign Mem_Addr   = {r_addr[31:2], 2'b00};
    assign Mem_W_En   = (r_state == ST_WRITE);
    assign Mem_W_Data = (r_state == ST_WRITE) ? r_data : 32'h0;
    assign Resp_Valid = r_resp_valid;
    assign Resp_Fault = r_resp_fault;
    assign Resp_RData = r_resp_rdata;

    lsu_lane_align u_align (
        .i_rdata  (Mem_R_Data),
        .i_off    (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_data),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    // Classify the incoming request: alignment, reserved size, address range.
    always_comb begin
        w_fault = 1'b0;
        case (Req_Size)
            SIZE_B:  w_fault = 1'b0;
            SIZE_H:  w_fault = Req_Addr[0];
            SIZE_W:  w_fault = |Req_Addr[1:0];
            default: w_fault = 1'b1;
        endcase
        if (CHECK_RANGE && ({1'b0, Req_Addr} >= ADDR_LIMIT)) begin
            w_fault = 1'b1;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_fault) begin
                    if (!Req_Write)              w_next = ST_LOAD;
                    else if (Req_Size == SIZE_W) w_next = ST_WRITE;
                    else                         w_next = ST_MERGE;
                end
            end
            ST_LOAD:  w_next = ST_IDLE;
            ST_MERGE: w_next = ST_WRITE;
            ST_WRITE: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight access.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Request latch, store data path and response registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_addr       <= 32'h0;
            r_data       <= 32'h0;
            r_size       <= SIZE_B;
            r_signed     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= 32'h0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_addr   <= Req_Addr;
                        r_data   <= Req_WData;
                        r_size   <= Req_Size;
                        r_signed <= Req_Signed;
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    r_resp_rdata <= w_load;
                    r_resp_valid <= 1'b1;
                end
                ST_MERGE: r_data       <= w_merge;
                ST_WRITE: r_resp_valid <= 1'b1;
                default:  r_resp_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: stimulus pushes expected responses and
// memory writes into queues, a negedge monitor pops and compares them.
// Instance 0 uses range checking, instance 1 has it disabled.
module tb_load_store_unit;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Reset;
    logic load_mem;

    logic        v0, w0, s0, v1, w1, s1;
    logic [1:0]  z0, z1;
    logic [31:0] a0, d0, a1, d1;
    logic        rdy0, rv0, rf0, wen0, rdy1, rv1, rf1, wen1;
    logic [31:0] rd0, ma0, wd0, mr0, rd1, ma1, wd1, mr1;

    logic [31:0] mem0 [64];
    logic [31:0] mem1 [64];

    load_store_unit #(.MEM_WORDS(64), .CHECK_RANGE(1)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(v0), .Req_Ready(rdy0), .Req_Write(w0), .Req_Size(z0),
        .Req_Signed(s0), .Req_Addr(a0), .Req_WData(d0),
        .Resp_Valid(rv0), .Resp_RData(rd0), .Resp_Fault(rf0),
        .Mem_Addr(ma0), .Mem_W_En(wen0), .Mem_W_Data(wd0), .Mem_R_Data(mr0)
    );

    load_store_unit #(.MEM_WORDS(64), .CHECK_RANGE(0)) u_dut_nr (
        .Clk(Clk), .Reset(Reset),
        .Req_Valid(v1), .Req_Ready(rdy1), .Req_Write(w1), .Req_Size(z1),
        .Req_Signed(s1), .Req_Addr(a1), .Req_WData(d1),
        .Resp_Valid(rv1), .Resp_RData(rd1), .Resp_Fault(rf1),
        .Mem_Addr(ma1), .Mem_W_En(wen1), .Mem_W_Data(wd1), .Mem_R_Data(mr1)
    );

    // Memory models: combinational read, synchronous word write.
    assign mr0 = mem0[ma0[7:2]];
    assign mr1 = mem1[ma1[7:2]];

    always @(posedge Clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
            mem0[4]  <= 32'h8899AABB;
            mem0[63] <= 32'hDEADBEEF;
        end else begin
            if (wen0) mem0[ma0[7:2]] <= wd0;
            if (wen1) mem1[ma1[7:2]] <= wd1;
        end
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        int          cyc;
    } wr_t;

    resp_t rq0[$];
    resp_t rq1[$];
    wr_t   wq0[$];
    wr_t   wq1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int last_acc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response and every memory write must match the next expectation.
    resp_t me;
    wr_t   mw;
    always @(negedge Clk) begin
        if (rv0) begin
            chk("resp0_expected", 32'(rq0.size() != 0), 32'd1);
            if (rq0.size() != 0) begin
                me = rq0.pop_front();
                chk("resp0_rdata", rd0, me.rdata);
                chk("resp0_fault", 32'(rf0), 32'(me.fault));
                chk("resp0_cycle", cyc, me.cyc);
            end
        end
        if (wen0) begin
            chk("write0_expected", 32'(wq0.size() != 0), 32'd1);
            if (wq0.size() != 0) begin
                mw = wq0.pop_front();
                chk("write0_data", wd0, mw.data);
                chk("write0_index", 32'(ma0[7:2]), 32'(mw.idx));
                chk("write0_cycle", cyc, mw.cyc);
            end
        end
        if (rv1) begin
            chk("resp1_expected", 32'(rq1.size() != 0), 32'd1);
            if (rq1.size() != 0) begin
                me = rq1.pop_front();
                chk("resp1_rdata", rd1, me.rdata);
                chk("resp1_fault", 32'(rf1), 32'(me.fault));
                chk("resp1_cycle", cyc, me.cyc);
            end
        end
        if (wen1) begin
            chk("write1_expected", 32'(wq1.size() != 0), 32'd1);
            if (wq1.size() != 0) begin
                mw = wq1.pop_front();
                chk("write1_data", wd1, mw.data);
                chk("write1_index", 32'(ma1[7:2]), 32'(mw.idx));
                chk("write1_cycle", cyc, mw.cyc);
            end
        end
    end

    // Present one request, wait (bounded) for acceptance, queue expectations.
    task automatic issue(input int inst, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic exp_rsp, input logic [31:0] exp_rd, input logic exp_f, input int lat,
                         input logic exp_wr, input logic [31:0] exp_wd, input int wlat);
        int    guard;
        resp_t r;
        wr_t   w;
        guard = 0;
        @(negedge Clk);
        while (((inst == 0) ? rdy0 : rdy1) == 1'b0 && guard < 50) begin
            @(negedge Clk);
            guard++;
        end
        chk("ready_wait", 32'(guard < 50), 32'd1);
        if (inst == 0) begin
            v0 = 1'b1; w0 = wr; z0 = sz; s0 = sg; a0 = addr; d0 = wd;
        end else begin
            v1 = 1'b1; w1 = wr; z1 = sz; s1 = sg; a1 = addr; d1 = wd;
        end
        last_acc = cyc;
        if (exp_rsp) begin
            r.rdata = exp_rd;
            r.fault = exp_f;
            r.cyc   = cyc + lat;
            if (inst == 0) rq0.push_back(r);
            else           rq1.push_back(r);
        end
        if (exp_wr) begin
            w.data = exp_wd;
            w.idx  = addr[7:2];
            w.cyc  = cyc + wlat;
            if (inst == 0) wq0.push_back(w);
            else           wq1.push_back(w);
        end
        @(posedge Clk);
        #1;
        if (inst == 0) v0 = 1'b0;
        else           v1 = 1'b0;
    endtask

    task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] addr, input logic [31:0] exp);
        issue(0, 1'b0, sz, sg, addr, 32'h0, 1'b1, exp, 1'b0, 2, 1'b0, 32'h0, 0);
    endtask

    task automatic acc_fault(input logic wr, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        issue(0, wr, sz, 1'b0, addr, wd, 1'b1, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_word);
        int lat;
        lat = (sz == 2'b10) ? 2 : 3;
        issue(0, 1'b1, sz, 1'b0, addr, wd, 1'b1, 32'h0, 1'b0, lat, 1'b1, exp_word, lat - 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((rq0.size() + rq1.size() + wq0.size() + wq1.size()) != 0 && g < 30) begin
            @(negedge Clk);
            g++;
        end
        repeat (3) @(negedge Clk);
    endtask

    int st_acc;

    initial begin
        Reset = 1'b1; load_mem = 1'b1;
        v0 = 0; w0 = 0; s0 = 0; z0 = 0; a0 = 0; d0 = 0;
        v1 = 0; w1 = 0; s1 = 0; z1 = 0; a1 = 0; d1 = 0;
        repeat (3) @(negedge Clk);
        load_mem = 1'b0;
        Reset    = 1'b0;
        @(negedge Clk);

        chk("rst_ready",    32'(rdy0), 32'd1);
        chk("rst_rvalid",   32'(rv0),  32'd0);
        chk("rst_fault",    32'(rf0),  32'd0);
        chk("rst_rdata",    rd0,       32'h0);
        chk("rst_wen",      32'(wen0), 32'd0);
        chk("rst_wdata",    wd0,       32'h0);
        chk("rst_mem_addr", ma0,       32'h0);

        // Loads from word 0x10 = 0x8899AABB
        ld(2'b00, 1'b1, 32'h13, 32'hFFFFFF88);
        ld(2'b00, 1'b0, 32'h13, 32'h00000088);
        ld(2'b01, 1'b1, 32'h12, 32'hFFFF8899);
        ld(2'b01, 1'b0, 32'h10, 32'h0000AABB);
        ld(2'b00, 1'b1, 32'h10, 32'hFFFFFFBB);
        ld(2'b10, 1'b1, 32'h10, 32'h8899AABB);
        // Top of memory: 0xFC holds 0xDEADBEEF
        ld(2'b10, 1'b0, 32'hFC, 32'hDEADBEEF);
        ld(2'b00, 1'b1, 32'hFF, 32'hFFFFFFDE);

        // Faults
        acc_fault(1'b0, 2'b01, 32'h11, 32'h0);
        acc_fault(1'b0, 2'b10, 32'h12, 32'h0);
        acc_fault(1'b0, 2'b11, 32'h10, 32'h0);
        acc_fault(1'b0, 2'b00, 32'h100, 32'h0);
        acc_fault(1'b1, 2'b10, 32'h100, 32'h12345678);
        drain();

        // Out-of-range store with range checking off wraps to word 0
        issue(1, 1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 1'b1, 32'h0, 1'b0, 2, 1'b1, 32'h12345678, 1);
        drain();
        chk("nr_mem_word0", mem1[0], 32'h12345678);

        // Reset during MERGE drops the store
        issue(0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF, 1'b0, 32'h0, 1'b0, 0, 1'b0, 32'h0, 0);
        Reset = 1'b1;
        #1;
        chk("midrst_wen", 32'(wen0), 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("midrst_ready", 32'(rdy0), 32'd1);
        repeat (4) @(negedge Clk);
        chk("midrst_mem", mem0[4], 32'h8899AABB);

        // Sub-word read-modify-write
        st(2'b00, 32'h11, 32'h000000CC, 32'h8899CCBB);
        ld(2'b10, 1'b0, 32'h10, 32'h8899CCBB);

        // Back-to-back store then load in the store's response cycle
        st(2'b10, 32'h14, 32'hCAFEF00D, 32'hCAFEF00D);
        st_acc = last_acc;
        ld(2'b10, 1'b0, 32'h14, 32'hCAFEF00D);
        chk("b2b_accept_cycle", last_acc, st_acc + 2);

        st(2'b01, 32'h16, 32'h1234BEEF, 32'hBEEFF00D);
        ld(2'b01, 1'b1, 32'h16, 32'hFFFFBEEF);
        ld(2'b10, 1'b0, 32'h14, 32'hBEEFF00D);
        drain();

        chk("left_resp0",  32'(rq0.size()), 32'd0);
        chk("left_write0", 32'(wq0.size()), 32'd0);
        chk("left_resp1",  32'(rq1.size()), 32'd0);
        chk("left_write1", 32'(wq1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage between the core's execute/control logic and the word-addressed data memory (64 x 32-bit, combinational read, synchronous word write on Clk).
- Handles byte, halfword and word loads/stores for LDR/LDRB/LDRH/STR/STRB/STRH, little-endian.
- Loads are sign- or zero-extended. Sub-word stores use a two-step read-modify-write, because the memory only accepts whole-word writes.
- Detects misaligned, reserved-size and out-of-range accesses and reports them as faults.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the data memory; byte addresses >= MEM_WORDS*4 fault.
- CHECK_RANGE, 1, 1 enables the out-of-range fault; 0 disables it (address bits above the memory index are ignored).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  core presents an access.
- Req_Ready  out  1  unit can accept; high only in IDLE.
- Req_Write  in  1  1 = store, 0 = load.
- Req_Size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Req_Signed  in  1  sign-extend load result; ignored for stores and for word loads.
- Req_Addr  in  32  byte address.
- Req_WData  in  32  store data, value in the low bits.
- Resp_Valid  out  1  one-cycle completion pulse.
- Resp_RData  out  32  load result, valid with Resp_Valid; 0 for stores and faults.
- Resp_Fault  out  1  access rejected, valid with Resp_Valid.
- Mem_Addr  out  32  word-aligned byte address to memory: {addr_q[31:2],2'b00}.
- Mem_W_En  out  1  memory write enable.
- Mem_W_Data  out  32  word written to memory.
- Mem_R_Data  in  32  combinational read data for Mem_Addr.

Behaviour:
- Reset:
  - State goes to IDLE asynchronously.
  - addr_q, data_q, Resp_RData, Mem_W_Data = 0.
  - Resp_Valid, Resp_Fault, Mem_W_En = 0.
  - Req_Ready = 1 once Reset deasserts.
- Reset mid-operation:
  - Any in-flight access is dropped; no write reaches memory and no response is produced.
  - Mem_W_En drops asynchronously with Reset.
- States: IDLE, LOAD, MERGE, WRITE.
- IDLE: accept when Req_Valid & Req_Ready. At that edge, latch addr, wdata, size, write and signed, then run the checks:
  - Faults:
    - size 11;
    - halfword with addr[0] = 1;
    - word with addr[1:0] != 0;
    - CHECK_RANGE = 1 and addr >= MEM_WORDS*4.
  - On a fault: stay in IDLE; next cycle Resp_Valid = 1, Resp_Fault = 1, Resp_RData = 0; memory is never written.
  - Otherwise go to LOAD (load), WRITE (word store; data_q = wdata) or MERGE (sub-word store).
  - Req_Valid while not ready is ignored; the core must hold the request.
- LOAD:
  - Extract the lane from Mem_R_Data. Byte = bits [8*a[1:0]+7 : 8*a[1:0]]; halfword = bits [16*a[1]+15 : 16*a[1]].
  - Extend per the latched signed bit and register it into Resp_RData.
  - Next cycle: Resp_Valid = 1 and state = IDLE.
- MERGE: replace the addressed byte or halfword lane of Mem_R_Data with the low bits of data_q, store the result into data_q, go to WRITE.
- WRITE:
  - Mem_W_En = 1 and Mem_W_Data = data_q for exactly this one cycle.
  - The write commits at the end-of-cycle edge.
  - Next cycle: Resp_Valid = 1, Resp_RData = 0, state = IDLE.
- Latency from the accept edge to the Resp_Valid cycle:
  - fault: 1 cycle;
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles.
- Resp_Valid is high for exactly one cycle per accepted request.
- Because Req_Ready is high in the same cycle as Resp_Valid, back-to-back requests are allowed. A load accepted in that cycle observes the preceding store's data.
- Mem_W_En is 0 in every state except WRITE.

Decomposition:
- Package lsu_pkg:
  - size encodings SIZE_B, SIZE_H, SIZE_W;
  - state enum;
  - shared constant for the byte-lane width.
- Sub-module lsu_lane_align: combinational lane extract/extend for loads and lane merge for stores, used by LOAD and MERGE. Instantiated once.

Test Plan (memory word 0x10 preloaded with 0x8899AABB):
- LDRB signed at 0x13 -> Resp_Valid 2 cycles after accept, Resp_RData 0xFFFFFF88; unsigned -> 0x00000088.
- LDRH signed at 0x12 -> 0xFFFF8899; LDRH at 0x11 -> Resp_Fault = 1, Resp_Valid 1 cycle after accept, Resp_RData 0.
- STRB 0x000000CC at 0x11 -> Mem_W_En high exactly in cycle 2 with Mem_W_Data 0x8899CCBB, Resp_Valid in cycle 3; then LDR 0x10 -> 0x8899CCBB.
- STR 0x12345678 at 0x100 with MEM_WORDS = 64 -> Resp_Fault = 1, Mem_W_En never asserted; with CHECK_RANGE = 0 -> write to word 0, no fault.
- STRH 0xBEEF at 0x10, Reset pulsed during the MERGE cycle -> no Mem_W_En, no Resp_Valid, word stays 0x8899AABB, Req_Ready = 1 after release.
- STR 0xCAFEF00D at 0x14, then LDR 0x14 issued in the store's Resp_Valid cycle -> accepted immediately, Resp_RData 0xCAFEF00D two cycles later.
